// File: rtl/conv_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_sink_pkg
// Purpose  : Shared types and constants for the convolution frame sink.
// Revision : 1.0
// ============================================================================
package conv_sink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int W_DEF  = 220;
    localparam int H_DEF  = 220;
    localparam int K_DEF  = 3;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    localparam int OW   = W_DEF - K_DEF + 1;
    localparam int OH   = H_DEF - K_DEF + 1;
    localparam int NPIX = OW * OH;

    localparam int ENTRY_W_DEF = AW_DEF + DW_DEF;

    // FIFO entry holds {address, pixel}
    function automatic int entry_w(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO; push while full succeeds only with a pop.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/conv_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_sink
// Purpose  : Addresses one convolved frame of pixels and writes it to memory.
// Revision : 1.0
// ============================================================================
module conv_frame_sink
    import conv_sink_pkg::*;
#(
    parameter int W     = 220,
    parameter int H     = 220,
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] pxl_in,
    input  logic          pxl_valid,
    output logic          mem_wr_valid,
    input  logic          mem_wr_ready,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    output logic [AW-1:0] pixel_count
);
    localparam int            OW_L   = W - K + 1;
    localparam int            OH_L   = H - K + 1;
    localparam logic [AW-1:0] NPIX_L = AW'(OW_L * OH_L);
    localparam int            EW     = entry_w(AW, DW);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0] fifo_head;

    assign fifo_pop = !fifo_empty && mem_wr_ready;

    // The pixel counter doubles as the write address: both advance on every
    // valid cycle, dropped pixels included.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            COLLECT: begin
                if (pxl_valid) begin
                    fifo_push = 1'b1;
                    cnt_d     = cnt_q + AW'(1);
                    if (fifo_full && !fifo_pop) begin
                        ovf_d = 1'b1;
                    end
                    if (cnt_d == NPIX_L) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({cnt_q, pxl_in}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign mem_wr_valid = !fifo_empty;
    assign mem_wr_addr  = fifo_empty ? '0 : fifo_head[EW-1:DW];
    assign mem_wr_data  = fifo_empty ? '0 : fifo_head[DW-1:0];
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign overflow     = ovf_q;
    assign pixel_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_sink
// Purpose  : Self-checking bench: small 3x3-output frame and a default frame.
// Revision : 1.0
// ============================================================================
module tb_conv_frame_sink;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int NP0   = 9;
    localparam int NP1   = 47524;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          s0 = 0, v0 = 0, r0 = 0, s1 = 0, v1 = 0, r1 = 0;
    logic [DW-1:0] d0 = 0, d1 = 0;
    logic          wv0, busy0, fd0, ov0, wv1, busy1, fd1, ov1;
    logic [AW-1:0] wa0, pc0, wa1, pc1;
    logic [DW-1:0] wd0, wd1;

    conv_frame_sink #(.W(5), .H(5), .K(3), .DW(DW), .AW(AW), .DEPTH(DEPTH)) u_small (
        .clk(clk), .reset(reset), .start(s0), .pxl_in(d0), .pxl_valid(v0),
        .mem_wr_valid(wv0), .mem_wr_ready(r0), .mem_wr_addr(wa0), .mem_wr_data(wd0),
        .busy(busy0), .frame_done(fd0), .overflow(ov0), .pixel_count(pc0));

    conv_frame_sink #(.W(220), .H(220), .K(3), .DW(DW), .AW(AW), .DEPTH(DEPTH)) u_full (
        .clk(clk), .reset(reset), .start(s1), .pxl_in(d1), .pxl_valid(v1),
        .mem_wr_valid(wv1), .mem_wr_ready(r1), .mem_wr_addr(wa1), .mem_wr_data(wd1),
        .busy(busy1), .frame_done(fd1), .overflow(ov1), .pixel_count(pc1));

    int n_assert = 0;
    int n_fail   = 0;

    // Frame model: phase 0 idle, 1 collecting, 2 draining, 3 done.
    int          ph   [2];
    int          cnt  [2];
    bit          movf [2];
    int unsigned mq   [2][$];

    int          done_n [2];
    logic [23:0] log0[$];
    logic [23:0] log1[$];
    int          wr1 = 0;
    int          last1 = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int np, input logic rst, input logic st,
                              input logic v, input logic [7:0] d, input logic rdy);
        int sz;
        bit pop;
        if (rst) begin
            ph[i] = 0; cnt[i] = 0; movf[i] = 0; mq[i].delete();
            return;
        end
        sz  = mq[i].size();
        pop = (sz > 0) && (rdy === 1'b1);
        case (ph[i])
            0: if (st === 1'b1) begin ph[i] = 1; cnt[i] = 0; movf[i] = 0; end
            1: if (v === 1'b1) begin
                   if (sz < DEPTH || pop) mq[i].push_back(cnt[i] * 256 + int'(d));
                   else movf[i] = 1;
                   cnt[i]++;
                   if (cnt[i] == np) ph[i] = 2;
               end
            2: if (sz == 0) ph[i] = 3;
            default: ph[i] = 0;
        endcase
        if (pop) void'(mq[i].pop_front());
    endtask

    always @(posedge clk) begin
        model_step(0, NP0, reset, s0, v0, d0, r0);
        model_step(1, NP1, reset, s1, v1, d1, r1);
    end

    always @(negedge clk) begin
        chk("valid0", {31'd0, wv0}, {31'd0, mq[0].size() != 0});
        if (mq[0].size() != 0) chk("head0", {8'd0, wa0, wd0}, mq[0][0]);
        chk("busy0", {31'd0, busy0}, {31'd0, ph[0] != 0});
        chk("done0", {31'd0, fd0}, {31'd0, ph[0] == 3});
        chk("ovf0", {31'd0, ov0}, {31'd0, movf[0]});
        chk("cnt0", {16'd0, pc0}, cnt[0]);
        chk("valid1", {31'd0, wv1}, {31'd0, mq[1].size() != 0});
        if (mq[1].size() != 0) chk("head1", {8'd0, wa1, wd1}, mq[1][0]);
        chk("busy1", {31'd0, busy1}, {31'd0, ph[1] != 0});
        chk("done1", {31'd0, fd1}, {31'd0, ph[1] == 3});
        chk("ovf1", {31'd0, ov1}, {31'd0, movf[1]});
        chk("cnt1", {16'd0, pc1}, cnt[1]);
        if (wv0 === 1'b1 && r0 === 1'b1) log0.push_back({wa0, wd0});
        if (wv1 === 1'b1 && r1 === 1'b1) begin
            wr1++;
            last1 = int'(wa1);
            if (log1.size() < 64) log1.push_back({wa1, wd1});
        end
        if (fd0 === 1'b1) done_n[0]++;
        if (fd1 === 1'b1) done_n[1]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, input int maxc);
        int base = done_n[i];
        for (int k = 0; k < maxc && done_n[i] == base; k++) step();
        n_assert++;
        if (done_n[i] == base) begin
            n_fail++;
            $display("FAIL wait_done%0d: no frame_done within %0d cycles", i, maxc);
        end
    endtask

    function automatic logic [31:0] log0_at(input int k);
        return (k < log0.size()) ? {8'd0, log0[k]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] log1_at(input int k);
        return (k < log1.size()) ? {8'd0, log1[k]} : 32'hFFFF_FFFF;
    endfunction

    task automatic run_small(input int base_data, input int rdy_on_k, input int start_again_k);
        s0 = 1; step(); s0 = 0;
        for (int k = 0; k < NP0; k++) begin
            v0 = 1; d0 = 8'(base_data + k);
            if (k == rdy_on_k) r0 = 1;
            s0 = (k == start_again_k);
            step();
        end
        v0 = 0; s0 = 0; r0 = 1;
        wait_done(0, 60);
    endtask

    task automatic check_small_log(input string name, input int base_data);
        chk({name, "_len"}, log0.size(), NP0);
        for (int k = 0; k < NP0; k++)
            chk(name, log0_at(k), {8'd0, 16'(k), 8'(base_data + k)});
    endtask

    initial begin
        int pushed, cyc;
        done_n[0] = 0; done_n[1] = 0;
        reset = 1;
        step(); step(); step();
        reset = 0;
        chk("rst_valid", {31'd0, wv0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_cnt", {16'd0, pc0}, 0);
        step();

        // 1: nine pixels, ready held high
        log0.delete(); done_n[0] = 0; r0 = 1;
        run_small(1, 0, -1);
        check_small_log("t1_wr", 1);
        chk("t1_done_n", done_n[0], 1);
        chk("t1_ovf", {31'd0, ov0}, 0);
        chk("t1_cnt", {16'd0, pc0}, 9);

        // 2: ready low for the first six push cycles
        log0.delete(); done_n[0] = 0; r0 = 0;
        run_small(1, 6, -1);
        check_small_log("t2_wr", 1);
        chk("t2_ovf", {31'd0, ov0}, 0);

        // 3: ten pixels into a blocked FIFO; the ninth is dropped
        log1.delete(); wr1 = 0; r1 = 0;
        s1 = 1; step(); s1 = 0;
        for (int k = 0; k < 10; k++) begin
            v1 = 1; d1 = 8'(k + 16);
            if (k == 9) r1 = 1;
            step();
            if (k == 7) chk("t3_ovf_pre", {31'd0, ov1}, 0);
            if (k == 8) chk("t3_ovf_9th", {31'd0, ov1}, 1);
        end
        v1 = 0;
        repeat (12) step();
        chk("t3_len", log1.size(), 9);
        for (int k = 0; k < 8; k++) chk("t3_wr", log1_at(k), {8'd0, 16'(k), 8'(k + 16)});
        chk("t3_wr_last", log1_at(8), {8'd0, 16'd9, 8'd25});
        chk("t3_cnt", {16'd0, pc1}, 10);
        chk("t3_ovf", {31'd0, ov1}, 1);
        reset = 1; step(); reset = 0; step();

        // 4: valids before start are ignored; a second start mid-frame is ignored
        log0.delete(); done_n[0] = 0; r0 = 1;
        for (int k = 0; k < 5; k++) begin v0 = 1; d0 = 8'hAA; step(); end
        v0 = 0;
        chk("t4_no_wr", log0.size(), 0);
        chk("t4_busy", {31'd0, busy0}, 0);
        run_small(1, 0, 3);
        check_small_log("t4_wr", 1);
        chk("t4_done_n", done_n[0], 1);
        repeat (3) step();
        chk("t4_idle", {31'd0, busy0}, 0);

        // 5: reset with four pixels queued
        log0.delete(); r0 = 0;
        s0 = 1; step(); s0 = 0;
        for (int k = 0; k < 4; k++) begin v0 = 1; d0 = 8'(k + 1); step(); end
        v0 = 0;
        chk("t5_queued", {31'd0, wv0}, 1);
        reset = 1; step(); reset = 0;
        chk("t5_valid", {31'd0, wv0}, 0);
        chk("t5_addr", {16'd0, wa0}, 0);
        chk("t5_data", {24'd0, wd0}, 0);
        chk("t5_busy", {31'd0, busy0}, 0);
        chk("t5_done", {31'd0, fd0}, 0);
        chk("t5_ovf", {31'd0, ov0}, 0);
        chk("t5_cnt", {16'd0, pc0}, 0);
        r0 = 1;
        repeat (5) step();
        chk("t5_no_wr", log0.size(), 0);
        done_n[0] = 0;
        run_small(50, 0, -1);
        check_small_log("t5_wr", 50);

        // 6: full default frame, valid 2 of 3 cycles, ready mostly high
        done_n[1] = 0; wr1 = 0; last1 = -1;
        s1 = 1; step(); s1 = 0;
        pushed = 0; cyc = 0;
        while (pushed < NP1) begin
            v1 = (cyc % 3 != 2);
            d1 = 8'(cyc);
            r1 = ($urandom_range(0, 15) != 0);
            if (v1) pushed++;
            step();
            cyc++;
        end
        v1 = 0; r1 = 1;
        wait_done(1, 100);
        chk("t6_writes", wr1, NP1);
        chk("t6_last", last1, NP1 - 1);
        chk("t6_done_n", done_n[1], 1);
        chk("t6_ovf", {31'd0, ov1}, 0);
        chk("t6_cnt", {16'd0, pc1}, NP1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
